// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM state type and primitive tap masks
// for the lfsr_bist pattern generator / self-test block.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    localparam logic [3:0]  TAPS_4  = 4'b1100;
    localparam logic [7:0]  TAPS_8  = 8'b10111000;
    localparam logic [15:0] TAPS_16 = 16'hB400;

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR state register with seed load, step
// and (when LFSR_SCAN_EN is defined) a serial scan-shift path.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             load,
    input  logic             step,
`ifdef LFSR_SCAN_EN
    input  logic             scan_en,
    input  logic             scan_in,
`endif
    output logic [WIDTH-1:0] state
);

    logic             fb;
    logic [WIDTH-1:0] nxt;

    // Feedback is the parity of the tapped state bits.
    always_comb begin
        fb  = ^(state & TAPS);
        nxt = {state[WIDTH-2:0], fb};
    end

    // State register: reset > scan > load > step > hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= seed;
`ifdef LFSR_SCAN_EN
        end else if (scan_en) begin
            state <= {state[WIDTH-2:0], scan_in};
`endif
        end else if (load) begin
            state <= seed;
        end else if (step) begin
            state <= nxt;
        end
    end

endmodule

// File: rtl/lfsr_bist.sv
// lfsr_bist: LFSR with hardware period measurement (IDLE/RUN/DONE).
// Optional scan access is enabled by defining LFSR_SCAN_EN.
module lfsr_bist
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             load,
    input  logic             enable,
    input  logic             start,
`ifdef LFSR_SCAN_EN
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
`endif
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   period,
    output logic             maximal,
    output logic             timeout
);

    localparam logic [WIDTH:0] CNT_MAX = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] MAX_P   = {1'b0, {WIDTH{1'b1}}};

    bist_state_t      fsm;
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH:0]   cnt;
    logic             hit;
    logic             core_load;
    logic             core_step;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .seed    (seed),
        .load    (core_load),
        .step    (core_step),
`ifdef LFSR_SCAN_EN
        .scan_en (scan_en),
        .scan_in (scan_in),
`endif
        .state   (out)
    );

`ifdef LFSR_SCAN_EN
    assign scan_out = out[WIDTH-1];
`endif

    assign hit = (out == ref_q);

    // Core control: IDLE honours load > start/enable; RUN steps until hit or limit.
    always_comb begin
        core_load = 1'b0;
        core_step = 1'b0;
        case (fsm)
            IDLE: begin
                core_load = load;
                core_step = !load && (start || enable);
            end
            RUN: begin
                core_step = !hit && (cnt != CNT_MAX);
            end
            default: begin
                core_load = 1'b0;
                core_step = 1'b0;
            end
        endcase
    end

    // Measurement FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm     <= IDLE;
            ref_q   <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            period  <= '0;
            maximal <= 1'b0;
            timeout <= 1'b0;
`ifdef LFSR_SCAN_EN
        end else if (scan_en) begin
            fsm  <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
`endif
        end else begin
            case (fsm)
                IDLE: begin
                    done <= 1'b0;
                    if (!load && start) begin
                        fsm     <= RUN;
                        ref_q   <= out;
                        cnt     <= {{WIDTH{1'b0}}, 1'b1};
                        busy    <= 1'b1;
                        period  <= '0;
                        maximal <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                RUN: begin
                    if (hit) begin
                        fsm     <= DONE;
                        period  <= cnt;
                        maximal <= (cnt == MAX_P);
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (cnt == CNT_MAX) begin
                        fsm     <= DONE;
                        timeout <= 1'b1;
                        period  <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    fsm  <= IDLE;
                    done <= 1'b0;
                end
                default: begin
                    fsm  <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_bist.sv
// tb_lfsr_bist: three 4-bit instances (taps 1100, 1010, 0011) driven
// in parallel and checked against a sequence-level reference model.
module tb_lfsr_bist;

    logic       clk;
    logic       rst;
    logic [3:0] seed;
    logic       load;
    logic       enable;
    logic       start;
    logic       scan_en;
    logic       scan_in;

    logic [3:0] out_w    [3];
    logic [4:0] period_w [3];
    logic [2:0] busy_w;
    logic [2:0] done_w;
    logic [2:0] maximal_w;
    logic [2:0] timeout_w;
    logic [2:0] scan_out_w;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam logic [3:0] T = (g == 0) ? 4'b1100 :
                                   (g == 1) ? 4'b1010 : 4'b0011;
        lfsr_bist #(
            .WIDTH (4),
            .TAPS  (T)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .seed     (seed),
            .load     (load),
            .enable   (enable),
            .start    (start),
`ifdef LFSR_SCAN_EN
            .scan_en  (scan_en),
            .scan_in  (scan_in),
            .scan_out (scan_out_w[g]),
`endif
            .out      (out_w[g]),
            .busy     (busy_w[g]),
            .done     (done_w[g]),
            .period   (period_w[g]),
            .maximal  (maximal_w[g]),
            .timeout  (timeout_w[g])
        );
    end

`ifndef LFSR_SCAN_EN
    assign scan_out_w = '0;
`endif

    // ---------------- reference model ----------------
    function automatic logic [3:0] taps_of(input int g);
        case (g)
            0: return 4'b1100;
            1: return 4'b1010;
            default: return 4'b0011;
        endcase
    endfunction

    function automatic logic [3:0] mstep(input logic [3:0] s, input logic [3:0] t);
        int ones;
        ones = $countones(s & t);
        return {s[2:0], (ones % 2 == 1)};
    endfunction

    // Steps until the start value reappears; 0 means not within 16 steps.
    function automatic int mperiod(input logic [3:0] s0, input logic [3:0] t);
        logic [3:0] s;
        s = s0;
        for (int n = 1; n <= 16; n++) begin
            s = mstep(s, taps_of_dummy(t));
            if (s == s0) return n;
        end
        return 0;
    endfunction

    function automatic logic [3:0] taps_of_dummy(input logic [3:0] t);
        return t;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] s);
        seed = s;
        rst  = 1'b0;
        tick();
        rst  = 1'b1;
    endtask

    // Measure from seed s; gmask selects which instances are checked.
    task automatic measure(input logic [3:0] s, input bit noise, input logic [2:0] gmask);
        int p    [3];
        int tgt  [3];
        int bcnt [3];
        int dcnt [3];
        int didx [3];
        do_reset(s);
        for (int g = 0; g < 3; g++) begin
            p[g]    = mperiod(s, taps_of(g));
            tgt[g]  = (p[g] != 0) ? p[g] : 16;
            bcnt[g] = 0;
            dcnt[g] = 0;
            didx[g] = -1;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int idx = 0; idx < 24; idx++) begin
            for (int g = 0; g < 3; g++) begin
                if (busy_w[g]) bcnt[g]++;
                if (done_w[g]) begin
                    dcnt[g]++;
                    didx[g] = idx;
                end
            end
            if (noise && idx < 10) begin
                load   = $urandom_range(0, 1);
                enable = $urandom_range(0, 1);
                start  = $urandom_range(0, 1);
                seed   = 4'($urandom);
            end else begin
                load   = 1'b0;
                enable = 1'b0;
                start  = 1'b0;
                seed   = s;
            end
            tick();
        end
        for (int g = 0; g < 3; g++) begin
            if (gmask[g]) begin
                checks++;
                if (bcnt[g] !== tgt[g]) begin
                    errors++;
                    $display("FAIL busy_cycles g%0d seed=%0d: got %0d want %0d", g, s, bcnt[g], tgt[g]);
                end
                checks++;
                if (dcnt[g] !== 1 || didx[g] !== tgt[g]) begin
                    errors++;
                    $display("FAIL done_pulse g%0d seed=%0d: got count %0d at %0d want 1 at %0d",
                             g, s, dcnt[g], didx[g], tgt[g]);
                end
                checks++;
                if (period_w[g] !== 5'(p[g])) begin
                    errors++;
                    $display("FAIL period g%0d seed=%0d: got %0d want %0d", g, s, period_w[g], p[g]);
                end
                checks++;
                if (maximal_w[g] !== (p[g] == 15)) begin
                    errors++;
                    $display("FAIL maximal g%0d seed=%0d: got %0b want %0b", g, s, maximal_w[g], p[g] == 15);
                end
                checks++;
                if (timeout_w[g] !== (p[g] == 0)) begin
                    errors++;
                    $display("FAIL timeout g%0d seed=%0d: got %0b want %0b", g, s, timeout_w[g], p[g] == 0);
                end
                if (p[g] != 0) begin
                    checks++;
                    if (out_w[g] !== s) begin
                        errors++;
                        $display("FAIL end_state g%0d seed=%0d: got %0d want %0d", g, s, out_w[g], s);
                    end
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [3:0] s;
        s = 4'($urandom);
        do_reset(s);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (out_w[g] !== s || busy_w[g] !== 1'b0 || done_w[g] !== 1'b0 ||
                period_w[g] !== 5'd0 || maximal_w[g] !== 1'b0 || timeout_w[g] !== 1'b0) begin
                errors++;
                $display("FAIL reset g%0d: got out=%0d busy=%0b done=%0b per=%0d max=%0b to=%0b want out=%0d zeros",
                         g, out_w[g], busy_w[g], done_w[g], period_w[g], maximal_w[g], timeout_w[g], s);
            end
        end
    endtask

    task automatic test_free_run();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'd3, 4'd6, 4'd13, 4'd10};
        do_reset(4'd3);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_w[0] !== exp_seq[i]) begin
                errors++;
                $display("FAIL free_run step %0d: got %0d want %0d", i, out_w[0], exp_seq[i]);
            end
            if (i < 3) tick();
        end
        enable = 1'b0;
        tick();
        checks++;
        if (out_w[0] !== 4'd10) begin
            errors++;
            $display("FAIL free_run hold: got %0d want 10", out_w[0]);
        end
    endtask

    task automatic test_random_idle();
        logic [3:0] m [3];
        int bad;
        do_reset(4'($urandom));
        for (int g = 0; g < 3; g++) m[g] = seed;
        for (int c = 0; c < 200; c++) begin
            seed   = 4'($urandom);
            load   = ($urandom_range(0, 7) == 0);
            enable = $urandom_range(0, 1);
            tick();
            bad = 0;
            for (int g = 0; g < 3; g++) begin
                if (load) m[g] = seed;
                else if (enable) m[g] = mstep(m[g], taps_of(g));
                checks++;
                if (out_w[g] !== m[g]) begin
                    errors++;
                    $display("FAIL idle_seq g%0d cycle %0d: got %0d want %0d", g, c, out_w[g], m[g]);
                end
            end
        end
        load   = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_maximal();
        measure(4'd3, 1'b0, 3'b111);
    endtask

    task automatic test_non_maximal();
        measure(4'd1, 1'b0, 3'b111);
    endtask

    task automatic test_lockup_timeout();
        measure(4'd0, 1'b0, 3'b111);
        measure(4'd8, 1'b0, 3'b111);
    endtask

    task automatic test_run_ignores_inputs();
        measure(4'd3, 1'b1, 3'b001);
    endtask

    task automatic test_random_measure();
        for (int i = 0; i < 6; i++) measure(4'($urandom), 1'b0, 3'b111);
    endtask

    task automatic test_back_to_back();
        measure(4'd8, 1'b0, 3'b111);
        // instance 2 has timed out and sits at 0; instance 0 is back at 8
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (timeout_w[2] !== 1'b0 || period_w[2] !== 5'd0 || busy_w[2] !== 1'b1) begin
            errors++;
            $display("FAIL start_clears: got to=%0b per=%0d busy=%0b want 0 0 1",
                     timeout_w[2], period_w[2], busy_w[2]);
        end
        checks++;
        if (period_w[0] !== 5'd0 || maximal_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_g0: got per=%0d max=%0b want 0 0", period_w[0], maximal_w[0]);
        end
        tick();
        checks++;
        if (done_w[2] !== 1'b1 || period_w[2] !== 5'd1 || maximal_w[2] !== 1'b0) begin
            errors++;
            $display("FAIL lockup_restart: got done=%0b per=%0d max=%0b want 1 1 0",
                     done_w[2], period_w[2], maximal_w[2]);
        end
        repeat (20) tick();
        checks++;
        if (period_w[0] !== 5'd15 || maximal_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_g0: got per=%0d max=%0b want 15 1", period_w[0], maximal_w[0]);
        end
    endtask

    task automatic test_abort();
        int dseen;
        measure(4'd8, 1'b0, 3'b000);
        seed  = 4'd3;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || out_w[0] !== 4'd3 ||
            period_w[0] !== 5'd0 || maximal_w[0] !== 1'b0 || timeout_w[2] !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: got busy=%0b done=%0b out=%0d per=%0d max=%0b to2=%0b want 0 0 3 0 0 0",
                     busy_w[0], done_w[0], out_w[0], period_w[0], maximal_w[0], timeout_w[2]);
        end
        dseen = 0;
        for (int c = 0; c < 20; c++) begin
            if (done_w != 3'b000 || busy_w != 3'b000) dseen++;
            tick();
        end
        checks++;
        if (dseen !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", dseen);
        end
    endtask

`ifdef LFSR_SCAN_EN
    task automatic test_scan();
        logic [3:0] bits;
        bits = 4'b1011;
        do_reset(4'd0);
        seed    = 4'd5;
        scan_en = 1'b1;
        start   = 1'b1;
        load    = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            scan_in = bits[i];
            tick();
        end
        scan_en = 1'b0;
        start   = 1'b0;
        load    = 1'b0;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (out_w[g] !== 4'd11 || scan_out_w[g] !== 1'b1 || busy_w[g] !== 1'b0) begin
                errors++;
                $display("FAIL scan_shift g%0d: got out=%0d so=%0b busy=%0b want 11 1 0",
                         g, out_w[g], scan_out_w[g], busy_w[g]);
            end
        end
    endtask

    task automatic test_scan_abort();
        int dseen;
        do_reset(4'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        scan_en = 1'b1;
        scan_in = 1'b0;
        tick();
        scan_en = 1'b0;
        checks++;
        if (busy_w !== 3'b000 || done_w !== 3'b000 || period_w[0] !== 5'd0) begin
            errors++;
            $display("FAIL scan_abort: got busy=%b done=%b per=%0d want 000 000 0",
                     busy_w, done_w, period_w[0]);
        end
        dseen = 0;
        for (int c = 0; c < 20; c++) begin
            if (done_w != 3'b000) dseen++;
            tick();
        end
        checks++;
        if (dseen !== 0) begin
            errors++;
            $display("FAIL scan_abort_no_done: got %0d done cycles want 0", dseen);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        seed    = 4'd3;
        load    = 1'b0;
        enable  = 1'b0;
        start   = 1'b0;
        scan_en = 1'b0;
        scan_in = 1'b0;
        tick();
        rst = 1'b1;
        test_reset();
        test_free_run();
        test_random_idle();
        test_maximal();
        test_non_maximal();
        test_lockup_timeout();
        test_run_ignores_inputs();
        test_random_measure();
        test_back_to_back();
        test_abort();
`ifdef LFSR_SCAN_EN
        test_scan();
        test_scan_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_bist.md
# lfsr_bist

Parametrised Fibonacci LFSR with built-in period self-test and optional scan access. It generalises the fixed 4-bit LFSR to any width and tap set. It adds an on-chip FSM that measures the sequence period from the current state, so the period-counting testbench loop moves into hardware. It serves as the pattern generator and self-check unit for BIST and test infrastructure.

## Interface
- WIDTH, 4: LFSR width in bits, ≥2.
- TAPS, 4'b1100: feedback mask, WIDTH bits; bit i set means state[i] is XORed into the feedback. The default is x^4+x^3+1.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; one clock, reset is synchronous and active-low.
- seed  in  WIDTH  value loaded into the state on reset or load.
- load  in  1  load seed into the state (IDLE only).
- enable  in  1  free-run step in IDLE.
- start  in  1  begin a period measurement (IDLE only).
- out  out  WIDTH  current LFSR state (registered).
- busy  out  1  high while the measurement is running.
- done  out  1  one-cycle pulse when a measurement ends.
- period  out  WIDTH+1  measured period, held until the next start.
- maximal  out  1  period == 2^WIDTH−1, held.
- timeout  out  1  no return to the start state within 2^WIDTH steps, held.
- scan_en, scan_in  in  1  scan shift control and data (LFSR_SCAN_EN only).
- scan_out  out  1  scan data out, equal to state[WIDTH−1] (LFSR_SCAN_EN only).

## Operation
- Step function: fb = ^(state & TAPS); next = {state[WIDTH−2:0], fb}.
- Reset (rst==0 at an edge) loads state ← seed and returns the FSM to IDLE. It also clears busy, done, period, maximal and timeout.
- FSM states are IDLE, RUN and DONE.
- IDLE: priority is load > start > enable.
  - load: state ← seed.
  - start: ref ← state, state ← next, cnt ← 1, go to RUN.
  - enable: state ← next.
  - None of these asserted: hold.
- RUN, checked every edge:
  - If state == ref: period ← cnt, maximal ← (cnt == 2^WIDTH−1), go to DONE.
  - Else if cnt == 2^WIDTH: timeout ← 1, period ← 0, go to DONE.
  - Else: state ← next, cnt ← cnt+1.
  - load, start and enable are ignored while in RUN.
- DONE: done=1 for exactly one cycle, then go to IDLE. The state holds the start value, which equals ref after a successful run.
- start clears period, maximal and timeout on the same edge that it is accepted.
- All-zero state is the lockup case: it measures period 1 with maximal 0. It is not treated as an error.
- cnt is WIDTH+1 bits wide and never wraps.

## Timing
- out, busy, done, period, maximal and timeout are all registered outputs.
- Start accepted at edge k leads to done high in the cycle after edge k+P for period P. This gives P cycles of busy.
- A timeout produces done in the cycle after edge k+2^WIDTH.
- load and enable take effect on the next edge, with 1-cycle latency to out.
- Reset during RUN aborts the measurement with no done pulse. Outputs take their reset values after that edge.

## Configuration
- LFSR_SCAN_EN defined:
  - The scan_en, scan_in and scan_out ports exist.
  - When scan_en=1, state ← {state[WIDTH−2:0], scan_in}. This has priority over all functions except reset.
  - scan_en=1 in RUN or DONE aborts to IDLE with no done pulse and the flags unchanged.
- LFSR_SCAN_EN undefined: the scan ports are absent and there is no scan logic.

## Structure
- Package lfsr_pkg holds:
  - The FSM state enum (IDLE, RUN, DONE).
  - Default primitive tap constants: TAPS_4=4'b1100, TAPS_8=8'b10111000, TAPS_16=16'hB400.
- Sub-module lfsr_core holds the state register, the step function, the load/enable logic and the scan mux.
- lfsr_bist wraps lfsr_core and adds the FSM, ref, cnt and the result registers.

## Test plan
- Free run: WIDTH=4, TAPS=4'b1100, seed=3, reset, then enable for 3 cycles -> out sequence 3, 6, 13, 10.
- Maximal period: from seed=3, pulse start -> busy for 15 cycles, done pulse, period=15, maximal=1, timeout=0, out=3.
- Non-maximal taps: TAPS=4'b1010, seed=1, start -> period=6, maximal=0.
- Lockup and timeout:
  - seed=0 -> period=1, maximal=0.
  - TAPS=4'b0011, seed=8, start -> timeout=1 and period=0 after 16 cycles of busy.
- Abort: rst=0 in cycle 5 of RUN with seed=3 -> no done pulse, busy=0, out=3, flags cleared. With LFSR_SCAN_EN, scan_en in RUN -> IDLE with no done.
- Scan (LFSR_SCAN_EN): from out=0, shift scan_in 1,0,1,1 -> out=11 and scan_out=1. A start/load issued during scan is ignored.
